// File: rtl/palette_lut_banked_if.sv
// Palette request/response bundle: bank select, lookup, entry write and fade control in; colour, status out.
interface palette_lut_banked_if #(
  parameter int IDX_W  = 4,
  parameter int CH_W   = 4,
  parameter int BANK_W = 2
);
  logic              frame_start;
  logic [BANK_W-1:0] bank_req;
  logic              rd_valid;
  logic [IDX_W-1:0]  rd_index;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  wr_index;
  logic [3*CH_W-1:0] wr_color;
  logic [1:0]        fade_cmd;
  logic              busy;
  logic [BANK_W-1:0] active_bank;
  logic              out_valid;
  logic [CH_W-1:0]   red;
  logic [CH_W-1:0]   green;
  logic [CH_W-1:0]   blue;
  logic [3:0]        fade_level;
  logic              fade_done;

  modport master (
    output frame_start, bank_req, rd_valid, rd_index, wr_en, wr_bank, wr_index, wr_color, fade_cmd,
    input  busy, active_bank, out_valid, red, green, blue, fade_level, fade_done
  );

  modport slave (
    input  frame_start, bank_req, rd_valid, rd_index, wr_en, wr_bank, wr_index, wr_color, fade_cmd,
    output busy, active_bank, out_valid, red, green, blue, fade_level, fade_done
  );
endinterface

// File: rtl/palette_lut_banked.sv
// Banked programmable palette, lookup latency 2 cycles, one lookup per cycle with no backpressure.
// Brightness fading is built only with PALETTE_FADE_EN defined; otherwise the colour passes straight through.
module palette_lut_banked #(
  parameter int IDX_W       = 4,
  parameter int CH_W        = 4,
  parameter int NUM_BANKS   = 4,
  parameter int FADE_FRAMES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  palette_lut_banked_if.slave   io_pal
);
  localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int DEPTH   = NUM_BANKS * ENTRIES;
  localparam int AW      = BANK_W + IDX_W;
  localparam int COL_W   = 3 * CH_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic              w_busy;
  logic              w_clr_last;
  logic [AW-1:0]     r_clr_addr;
  logic [COL_W-1:0]  r_mem [DEPTH];
  logic              w_wr_ok, w_rd_go, w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [COL_W-1:0]  w_mem_wdat;
  logic [BANK_W-1:0] r_active_bank;
  logic              r_s1_vld;
  logic [COL_W-1:0]  r_s1_dat;
  logic [COL_W-1:0]  w_faded;
  logic              r_out_vld;
  logic [COL_W-1:0]  r_out_dat;
  logic [3:0]        w_fade_level;
  logic              w_fade_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  assign w_clr_last = (r_clr_addr == AW'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_busy = 1'b1;
        if (w_clr_last) w_state_nxt = ST_RUN;
      end
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_clr_addr <= '0;
    else if (w_busy) r_clr_addr <= r_clr_addr + 1'b1;
  end

  // The clear walk owns the RAM write port while busy; loader writes are ignored then.
  assign w_wr_ok    = !w_busy && io_pal.wr_en && (int'(io_pal.wr_bank) < NUM_BANKS);
  assign w_rd_go    = !w_busy && io_pal.rd_valid;
  assign w_mem_we   = !i_rst && (w_busy || w_wr_ok);
  assign w_mem_addr = w_busy ? r_clr_addr : {io_pal.wr_bank, io_pal.wr_index};
  assign w_mem_wdat = w_busy ? '0 : io_pal.wr_color;

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdat;
    if (w_rd_go)  r_s1_dat <= r_mem[{r_active_bank, io_pal.rd_index}];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld      <= 1'b0;
      r_active_bank <= '0;
    end else begin
      r_s1_vld <= w_rd_go;
      if (!w_busy && io_pal.frame_start && (int'(io_pal.bank_req) < NUM_BANKS))
        r_active_bank <= io_pal.bank_req;
    end
  end

`ifdef PALETTE_FADE_EN
  localparam int FC_W = $clog2(FADE_FRAMES) + 1;

  logic [3:0]      r_fade_level;
  logic            r_fading;
  logic            r_fade_in;
  logic [FC_W-1:0] r_frame_cnt;
  logic            w_cmd_new;

  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [3:0] lvl);
    logic [CH_W+3:0] p;
    p = (CH_W+4)'(c) * (CH_W+4)'({1'b0, lvl} + 5'd1);
    return CH_W'(p >> 4);
  endfunction

  // Repeating the running direction is a no-op so a held command does not stall the fade.
  assign w_cmd_new = ((io_pal.fade_cmd == 2'b01) && !(r_fading && !r_fade_in)) ||
                     ((io_pal.fade_cmd == 2'b10) && !(r_fading &&  r_fade_in));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fade_level <= 4'hF;
      r_fading     <= 1'b0;
      r_fade_in    <= 1'b0;
      r_frame_cnt  <= '0;
    end else if (io_pal.fade_cmd == 2'b11) begin
      r_fade_level <= 4'hF;
      r_fading     <= 1'b0;
      r_frame_cnt  <= '0;
    end else if (w_cmd_new) begin
      r_fade_in   <= io_pal.fade_cmd[1];
      r_frame_cnt <= '0;
      r_fading    <= io_pal.fade_cmd[1] ? (r_fade_level != 4'hF) : (r_fade_level != 4'h0);
    end else if (r_fading && io_pal.frame_start && !w_busy) begin
      if (r_frame_cnt == FC_W'(FADE_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        if (r_fade_in) begin
          r_fade_level <= r_fade_level + 4'd1;
          if (r_fade_level == 4'hE) r_fading <= 1'b0;
        end else begin
          r_fade_level <= r_fade_level - 4'd1;
          if (r_fade_level == 4'h1) r_fading <= 1'b0;
        end
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_fade_level = r_fade_level;
  assign w_fade_done  = !r_fading;
  assign w_faded      = {scale(r_s1_dat[3*CH_W-1:2*CH_W], r_fade_level),
                         scale(r_s1_dat[2*CH_W-1:CH_W],   r_fade_level),
                         scale(r_s1_dat[CH_W-1:0],        r_fade_level)};
`else
  localparam int unused_fade_frames = FADE_FRAMES;
  logic w_unused_fade_cmd;

  assign w_unused_fade_cmd = ^io_pal.fade_cmd;
  assign w_fade_level      = 4'hF;
  assign w_fade_done       = 1'b1;
  assign w_faded           = r_s1_dat;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) r_out_dat <= w_faded;
    end
  end

  assign io_pal.busy        = w_busy;
  assign io_pal.active_bank = r_active_bank;
  assign io_pal.out_valid   = r_out_vld;
  assign io_pal.red         = r_out_dat[3*CH_W-1:2*CH_W];
  assign io_pal.green       = r_out_dat[2*CH_W-1:CH_W];
  assign io_pal.blue        = r_out_dat[CH_W-1:0];
  assign io_pal.fade_level  = w_fade_level;
  assign io_pal.fade_done   = w_fade_done;
endmodule

// File: tb/tb_palette_lut_banked.sv
// Bench for palette_lut_banked: vector table plus hand sequences, lookups checked through a scoreboard queue.
module tb_palette_lut_banked;
  localparam int IDX_W = 4, CH_W = 4, NUM_BANKS = 4, FADE_FRAMES = 2, BANK_W = 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  palette_lut_banked_if #(.IDX_W(IDX_W), .CH_W(CH_W), .BANK_W(BANK_W)) bus ();

  palette_lut_banked #(.IDX_W(IDX_W), .CH_W(CH_W), .NUM_BANKS(NUM_BANKS), .FADE_FRAMES(FADE_FRAMES)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .io_pal (bus)
  );

  typedef struct {
    int          due;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    logic [1:0]  wb;
    logic [3:0]  wi;
    logic [11:0] wc;
    logic [3:0]  ri;
    logic [11:0] exp_rgb;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("lookup_rgb", {bus.red, bus.green, bus.blue}, mon_e.rgb);
        chk("lookup_latency", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    bus.frame_start = 1'b0;
    bus.bank_req    = '0;
    bus.rd_valid    = 1'b0;
    bus.rd_index    = '0;
    bus.wr_en       = 1'b0;
    bus.wr_bank     = '0;
    bus.wr_index    = '0;
    bus.wr_color    = '0;
    bus.fade_cmd    = 2'b00;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [11:0] exp_rgb);
    bus.rd_valid = 1'b1;
    bus.rd_index = idx;
    sb.push_back('{due: cyc + 2, rgb: exp_rgb});
    tick();
    bus.rd_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] bank, input logic [3:0] idx, input logic [11:0] col);
    bus.wr_en    = 1'b1;
    bus.wr_bank  = bank;
    bus.wr_index = idx;
    bus.wr_color = col;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic frame(input logic [1:0] breq);
    bus.frame_start = 1'b1;
    bus.bank_req    = breq;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic set_cmd(input logic [1:0] cmd);
    bus.fade_cmd = cmd;
    tick();
    bus.fade_cmd = 2'b00;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  // Entered on the first falling edge after reset release; loader/renderer/frame activity must all be ignored.
  task automatic init_run();
    int cnt;
    cnt = 0;
    bus.rd_valid    = 1'b1;
    bus.wr_en       = 1'b1;
    bus.wr_bank     = 2'd0;
    bus.wr_index    = 4'd2;
    bus.wr_color    = 12'hFFF;
    bus.frame_start = 1'b1;
    bus.bank_req    = 2'd2;
    for (int i = 0; i < 200 && bus.busy === 1'b1; i++) begin
      chk("init_out_valid", 32'(bus.out_valid), 32'd0);
      bus.rd_index = 4'($urandom_range(15));
      cnt++;
      tick();
    end
    idle_inputs();
    chk("init_busy_cycles", cnt, 64);
    chk("busy_after_init", 32'(bus.busy), 32'd0);
    chk("bank_after_init", 32'(bus.active_bank), 32'd0);
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{wb: 2'd0, wi: 4'd3,  wc: 12'h467, ri: 4'd3,  exp_rgb: 12'h467};
    vt[1] = '{wb: 2'd0, wi: 4'd0,  wc: 12'hABC, ri: 4'd0,  exp_rgb: 12'hABC};
    vt[2] = '{wb: 2'd0, wi: 4'd15, wc: 12'h123, ri: 4'd15, exp_rgb: 12'h123};
    vt[3] = '{wb: 2'd2, wi: 4'd5,  wc: 12'h555, ri: 4'd5,  exp_rgb: 12'h000};
    vt[4] = '{wb: 2'd0, wi: 4'd8,  wc: 12'hFFF, ri: 4'd8,  exp_rgb: 12'hFFF};
    vt[5] = '{wb: 2'd3, wi: 4'd0,  wc: 12'h321, ri: 4'd0,  exp_rgb: 12'hABC};

    idle_inputs();
    i_rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_active_bank", 32'(bus.active_bank), 32'd0);
    chk("rst_fade_level", 32'(bus.fade_level), 32'hF);
    chk("rst_fade_done", 32'(bus.fade_done), 32'd1);
    chk("rst_rgb", {bus.red, bus.green, bus.blue}, 32'h0);
    i_rst = 1'b0;
    init_run();

    // Every entry of every bank reads back as zero after the clear.
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (b != 0) frame(2'(b));
      chk("swap_for_clear_check", 32'(bus.active_bank), 32'(b));
      for (int i = 0; i < 16; i++) rd(4'(i), 12'h000);
      drain();
    end
    frame(2'd0);
    chk("back_to_bank0", 32'(bus.active_bank), 32'd0);

    for (int k = 0; k < 6; k++) begin
      wr(vt[k].wb, vt[k].wi, vt[k].wc);
      rd(vt[k].ri, vt[k].exp_rgb);
    end
    drain();

    rd(4'd3, 12'h467);
    rd(4'd0, 12'hABC);
    rd(4'd3, 12'h467);
    drain();

    // Same-cycle write and read of one entry returns the pre-write value.
    bus.wr_en    = 1'b1;
    bus.wr_bank  = 2'd0;
    bus.wr_index = 4'd9;
    bus.wr_color = 12'h9AB;
    rd(4'd9, 12'h000);
    bus.wr_en = 1'b0;
    rd(4'd9, 12'h9AB);
    drain();

    wr(2'd1, 4'd3, 12'hF00);
    bus.bank_req = 2'd1;
    tick();
    tick();
    chk("bank_req_without_frame", 32'(bus.active_bank), 32'd0);
    frame(2'd1);
    chk("bank_swap_to_1", 32'(bus.active_bank), 32'd1);
    rd(4'd3, 12'hF00);
    drain();

    // A lookup issued alongside frame_start still uses the bank in force that cycle.
    bus.frame_start = 1'b1;
    bus.bank_req    = 2'd0;
    rd(4'd3, 12'hF00);
    bus.frame_start = 1'b0;
    rd(4'd3, 12'h467);
    chk("bank_swap_to_0", 32'(bus.active_bank), 32'd0);
    drain();

    wr(2'd0, 4'd1, 12'hF84);
    rd(4'd1, 12'hF84);
    drain();

`ifdef PALETTE_FADE_EN
    set_cmd(2'b01);
    chk("fade_out_started_done", 32'(bus.fade_done), 32'd0);
    chk("fade_out_started_level", 32'(bus.fade_level), 32'hF);
    frame(2'd0);
    chk("fade_after_1_frame", 32'(bus.fade_level), 32'hF);
    frame(2'd0);
    chk("fade_after_2_frames", 32'(bus.fade_level), 32'hE);
    rd(4'd1, 12'hE73);
    drain();
    for (int i = 0; i < 28; i++) frame(2'd0);
    chk("fade_out_floor_level", 32'(bus.fade_level), 32'h0);
    chk("fade_out_floor_done", 32'(bus.fade_done), 32'd1);
    frame(2'd0);
    frame(2'd0);
    chk("fade_out_stays_0", 32'(bus.fade_level), 32'h0);
    rd(4'd1, 12'h000);
    drain();
    set_cmd(2'b11);
    chk("snap_level", 32'(bus.fade_level), 32'hF);
    chk("snap_done", 32'(bus.fade_done), 32'd1);
    rd(4'd1, 12'hF84);
    drain();

    set_cmd(2'b01);
    for (int i = 0; i < 4; i++) frame(2'd0);
    chk("fade_before_reverse", 32'(bus.fade_level), 32'hD);
    set_cmd(2'b10);
    frame(2'd0);
    chk("reverse_counter_cleared", 32'(bus.fade_level), 32'hD);
    frame(2'd0);
    chk("reverse_step_up", 32'(bus.fade_level), 32'hE);
    set_cmd(2'b11);

    set_cmd(2'b01);
    for (int i = 0; i < 12; i++) frame(2'd0);
    chk("mid_fade_level", 32'(bus.fade_level), 32'h9);
    rd(4'd1, 12'h952);
    drain();
`else
    set_cmd(2'b01);
    for (int i = 0; i < 4; i++) frame(2'd0);
    chk("nofade_level", 32'(bus.fade_level), 32'hF);
    chk("nofade_done", 32'(bus.fade_done), 32'd1);
    rd(4'd1, 12'hF84);
    drain();
`endif

    i_rst = 1'b1;
    tick();
    chk("rst2_fade_level", 32'(bus.fade_level), 32'hF);
    chk("rst2_fade_done", 32'(bus.fade_done), 32'd1);
    chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_rgb", {bus.red, bus.green, bus.blue}, 32'h0);
    chk("rst2_busy", 32'(bus.busy), 32'd1);
    i_rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_init_busy", 32'(bus.busy), 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    init_run();
    rd(4'd1, 12'h000);
    rd(4'd3, 12'h000);
    drain();

    chk("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
